fpga_echo_top: RTL and testbench

//  Minimal FPGA top: single-clock UART echo console with LED status and idle tie-offs for flash/SD pins.

---
 rtl/fpga_echo_pkg.sv | 25 ++
 rtl/fpga_echo_uart_rx.sv | 140 ++++++++++++++
 rtl/fpga_echo_top.sv | 220 ++++++++++++++++++++++
 tb/tb_fpga_echo_top.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_echo_pkg.sv
// ----------------------------------------------------------------------------
// fpga_echo_pkg
// Shared types and helpers for the UART echo bring-up top.
//   uart_state_e : state encoding used by both the RX and TX frame FSMs
//   DATA_BITS    : payload bits per UART frame (8N1)
//   calc_div     : clock cycles per UART bit for a given clock and baud rate
// ----------------------------------------------------------------------------
package fpga_echo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;

    // Integer cycles per bit; callers must pick rates giving a result >= 4.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/fpga_echo_uart_rx.sv
// ----------------------------------------------------------------------------
// fpga_echo_uart_rx
// 8N1 UART receiver: two-flop synchroniser followed by the RX frame FSM.
// Parameters:
//   DIV          clock cycles per UART bit (>= 4)
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous reset, active-low
//   rxd_i        raw serial input, idle high, asynchronous to clk_i
//   data_o       last received byte (valid while valid_o is high)
//   valid_o      one-cycle strobe: correctly framed byte on data_o
//   frame_err_o  one-cycle strobe: stop bit sampled low, byte discarded
// ----------------------------------------------------------------------------
module fpga_echo_uart_rx
    import fpga_echo_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o
);

    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_CNT = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic sync1_q, sync2_q, prev_q;

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    // Set after a bad stop bit: hold in STOP until the line goes idle again,
    // so a stuck-low line cannot be mistaken for a new start bit.
    logic                 err_wait_q, err_wait_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_wait_d = err_wait_q;
        case (state_q)
            IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Half-bit re-check rejects short glitches on the line.
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (sync2_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (err_wait_q) begin
                    if (sync2_q) begin
                        state_d    = IDLE;
                        err_wait_d = 1'b0;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d      = 1'b1;
                        err_wait_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_wait_q <= 1'b0;
        end else begin
            sync1_q    <= rxd_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_wait_q <= err_wait_d;
        end
    end

    assign data_o      = shift_q;
    assign valid_o     = valid_q;
    assign frame_err_o = err_q;

endmodule

// File: rtl/fpga_echo_top.sv
// ----------------------------------------------------------------------------
// fpga_echo_top
// Chip-level bring-up top: UART echo console with LED status and idle
// tie-offs for the flash and SD pins. Single clock domain (clk_p).
// Build option: define HW_FLOW_CTRL_EN to gate TX start on cts and drive
// rts from the echo buffer state; otherwise cts is ignored and rts is 1
// whenever the internal reset is released.
// Parameters:
//   CLK_FREQ_HZ  input clock frequency
//   BAUD         UART bit rate (CLK_FREQ_HZ/BAUD must be an integer >= 4)
//   RST_STRETCH  cycles the internal reset is held after rst_top rises (>= 1)
// Ports:
//   clk_p     system clock, rising edge
//   rst_top   synchronous reset, active-low
//   rxd       UART receive, 8N1, idle high, asynchronous
//   txd       UART transmit, 8N1, idle high
//   cts       clear-to-send, 1 = TX permitted
//   rts       ready-to-receive, 1 = echo buffer can accept a byte
//   o_led     last correctly framed received byte
//   flash_ss  flash chip select, held deselected (1)
//   sd_reset  SD reset control, 1 while the internal reset is active
// ----------------------------------------------------------------------------
module fpga_echo_top
    import fpga_echo_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned RST_STRETCH = 16
) (
    input  logic       clk_p,
    input  logic       rst_top,
    input  logic       rxd,
    output logic       txd,
    input  logic       cts,
    output logic       rts,
    output logic [7:0] o_led,
    output logic       flash_ss,
    output logic       sd_reset
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned BW  = $clog2(DATA_BITS);
    localparam int unsigned SW  = $clog2(RST_STRETCH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Reset stretch. rst_any also covers the cycle rst_top is first seen
    // low so that frames abort on that very edge.
    // ------------------------------------------------------------------
    logic          int_rst_q;
    logic [SW-1:0] stretch_q;
    logic          rst_any;

    always_ff @(posedge clk_p) begin
        if (!rst_top) begin
            int_rst_q <= 1'b1;
            stretch_q <= '0;
        end else if (stretch_q == SW'(RST_STRETCH)) begin
            int_rst_q <= 1'b0;
        end else begin
            stretch_q <= stretch_q + 1'b1;
        end
    end

    assign rst_any = !rst_top || int_rst_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;

    fpga_echo_uart_rx #(
        .DIV (DIV)
    ) u_rx (
        .clk_i       (clk_p),
        .rst_ni      (!rst_any),
        .rxd_i       (rxd),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .frame_err_o (rx_frame_err)
    );

    // ------------------------------------------------------------------
    // Echo buffer, LED register and transmitter
    // ------------------------------------------------------------------
    uart_state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 txd_q, txd_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic [7:0]           led_q, led_d;
    logic                 tx_permit;
    logic                 take;

`ifdef HW_FLOW_CTRL_EN
    assign tx_permit = cts;
`else
    assign tx_permit = 1'b1;
`endif

    assign take = (tx_state_q == IDLE) && buf_full_q && tx_permit;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        case (tx_state_q)
            IDLE: begin
                if (take) begin
                    tx_state_d = START;
                    tx_cnt_d   = '0;
                    tx_shift_d = buf_q;
                    txd_d      = 1'b0;
                end
            end
            START: begin
                if (tx_cnt_q == LAST_CNT) begin
                    tx_state_d = DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt_q == LAST_CNT) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt_q == LAST_CNT) begin
                    tx_state_d = IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // A take and a load in the same cycle: the take empties the slot first,
    // so the new byte is accepted rather than counted as an overrun.
    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        led_d      = led_q;
        if (take) begin
            buf_full_d = 1'b0;
        end
        if (rx_valid) begin
            led_d = rx_data;
            if (!buf_full_q || take) begin
                buf_d      = rx_data;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_p) begin
        if (rst_any) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            led_q      <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            led_q      <= led_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
`ifdef HW_FLOW_CTRL_EN
    assign rts = !int_rst_q && !buf_full_q;
`else
    assign rts = !int_rst_q;
`endif

    assign txd      = txd_q;
    assign o_led    = led_q;
    assign flash_ss = 1'b1;
    assign sd_reset = int_rst_q;

    // Framing errors need no action here (the byte is simply not echoed),
    // and cts is only consumed when flow control is built in.
    logic unused_ok;
    assign unused_ok = ^{rx_frame_err, cts};

endmodule

// File: tb/tb_fpga_echo_top.sv
module tb_fpga_echo_top;

    localparam int DIV = 16;

    logic       clk_p = 1'b0;
    logic       rst_top;
    logic       rxd;
    logic       txd;
    logic       cts;
    logic       rts;
    logic [7:0] o_led;
    logic       flash_ss;
    logic       sd_reset;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stop_cyc = 0;

    fpga_echo_top #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD        (100_000),
        .RST_STRETCH (16)
    ) dut (
        .clk_p    (clk_p),
        .rst_top  (rst_top),
        .rxd      (rxd),
        .txd      (txd),
        .cts      (cts),
        .rts      (rts),
        .o_led    (o_led),
        .flash_ss (flash_ss),
        .sd_reset (sd_reset)
    );

    always #5 clk_p = ~clk_p;
    always @(posedge clk_p) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_led;
        logic       exp_echo;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one 8N1 frame on rxd, LSB first, with the given stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk_p);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (DIV) @(negedge clk_p);
        end
        rxd = stop;
        stop_cyc = cyc;
        repeat (DIV) @(negedge clk_p);
        rxd = 1'b1;
        repeat (4) @(negedge clk_p);
    endtask

    // Wait (bounded) for a start bit on txd; if seen, compare every cycle of
    // the following frame against the ideal waveform for exp.
    task automatic capture(input int limit, input logic [7:0] exp,
                           output logic found, output int wave_errs, output int start_cyc);
        logic [9:0] frame;
        found     = 1'b0;
        wave_errs = 0;
        start_cyc = 0;
        frame     = {1'b1, exp, 1'b0};
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk_p);
            if (txd === 1'b0) begin
                found     = 1'b1;
                start_cyc = cyc;
            end
        end
        if (found) begin
            for (int s = 0; s < 10 * DIV; s++) begin
                if (s > 0) @(negedge clk_p);
                if (txd !== frame[s / DIV]) wave_errs++;
            end
        end
    endtask

    initial begin
        logic found;
        int   werr;
        int   scyc;
        int   lat;
        int   bad;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
        vecs[1] = '{8'h3C, 1'b0, 8'hA5, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 8'h81, 1'b1};

        rxd     = 1'b1;
        cts     = 1'b1;
        rst_top = 1'b0;

        // Reset and reset stretch
        repeat (4) @(negedge clk_p);
        check("rst_txd", txd, 1);
        check("rst_rts", rts, 0);
        check("rst_sd_reset", sd_reset, 1);
        check("rst_led", o_led, 0);
        check("flash_ss", flash_ss, 1);
        rst_top = 1'b1;
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk_p);
            if (sd_reset !== 1'b1 || rts !== 1'b0 || txd !== 1'b1) bad++;
        end
        check("stretch_held_cycles_bad", bad, 0);
        @(negedge clk_p);
        check("stretch_rts_released", rts, 1);
        check("stretch_sd_reset_released", sd_reset, 0);
        $display("reset: released after stretch, rts=%0b sd_reset=%0b", rts, sd_reset);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            fork
                send_frame(vecs[v].data, vecs[v].stop);
                capture(200, vecs[v].data, found, werr, scyc);
            join
            @(negedge clk_p);
            check("vec_led", o_led, vecs[v].exp_led);
            check("vec_echo_seen", found, vecs[v].exp_echo);
            if (vecs[v].exp_echo) begin
                lat = scyc - stop_cyc;
                check("vec_echo_wave_errs", werr, 0);
                check("vec_echo_latency_in_window", (lat >= 11 && lat <= 15), 1);
            end
            check("vec_rts", rts, 1);
            $display("vec %0d: data=%02h stop=%0b led=%02h echo=%0b", v,
                     vecs[v].data, vecs[v].stop, o_led, found);
        end

        // Short low glitch must not produce a byte
        rxd = 1'b0;
        repeat (4) @(negedge clk_p);
        rxd = 1'b1;
        capture(60, 8'h00, found, werr, scyc);
        check("glitch_no_echo", found, 0);
        check("glitch_led", o_led, 8'h81);
        $display("glitch: 4-cycle low, led=%02h echo=%0b", o_led, found);

        // Flow control
`ifdef HW_FLOW_CTRL_EN
        cts = 1'b0;
        fork
            send_frame(8'h11, 1'b1);
            capture(200, 8'h11, found, werr, scyc);
        join
        check("fc_blocked_no_echo", found, 0);
        check("fc_rts_full", rts, 0);
        check("fc_led_11", o_led, 8'h11);
        fork
            send_frame(8'h22, 1'b1);
            capture(200, 8'h22, found, werr, scyc);
        join
        check("fc_overrun_no_echo", found, 0);
        check("fc_led_22", o_led, 8'h22);
        cts = 1'b1;
        capture(20, 8'h11, found, werr, scyc);
        check("fc_release_echo_seen", found, 1);
        check("fc_release_wave_errs", werr, 0);
        check("fc_rts_after_tx", rts, 1);
        $display("flowctl: 0x11 held then echoed, 0x22 dropped, rts=%0b", rts);
`else
        cts = 1'b0;
        fork
            send_frame(8'h11, 1'b1);
            capture(200, 8'h11, found, werr, scyc);
        join
        check("cts_ignored_echo_seen", found, 1);
        check("cts_ignored_wave_errs", werr, 0);
        check("cts_ignored_rts", rts, 1);
        cts = 1'b1;
        $display("cts ignored: 0x11 echoed with cts=0, rts=%0b", rts);
`endif

        // Reset in the middle of TX data bit 3
        found = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 200 && !found; i++) begin
                    @(negedge clk_p);
                    if (txd === 1'b0) begin
                        found = 1'b1;
                        scyc  = cyc;
                    end
                end
            end
        join
        check("midtx_start_seen", found, 1);
        for (int i = 0; i < 200 && cyc < scyc + 72; i++) @(negedge clk_p);
        check("midtx_bit3_level", txd, 0);
        rst_top = 1'b0;
        @(negedge clk_p);
        check("midtx_rst_txd", txd, 1);
        check("midtx_rst_led", o_led, 0);
        check("midtx_rst_rts", rts, 0);
        check("midtx_rst_sd_reset", sd_reset, 1);
        repeat (3) @(negedge clk_p);
        rst_top = 1'b1;
        repeat (20) @(negedge clk_p);
        capture(200, 8'h00, found, werr, scyc);
        check("midtx_no_echo_after_reset", found, 0);
        check("midtx_rts_after_reset", rts, 1);
        $display("midtx reset: txd=%0b led=%02h echo_after=%0b", txd, o_led, found);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
